// File: rtl/adder_sub_serial.sv
// Multi-cycle add/subtract: B is inverted with carry-in for SUB, then CHUNK bits
// are summed per cycle, rippling the chunk carry, with start/done handshake.
module adder_sub_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             READY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY,
    output logic             OVERFLOW,
    output logic             ZERO
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, acc, acc_nxt;
    logic             cin;
    logic [IW-1:0]    idx;
    logic [CHUNK:0]   csum;
    logic             last;

    assign last = (idx == IW'(N - 1));

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        READY     = 1'b0;
        DONE      = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted so no request is signalled as accepted.
                READY = RST;
                if (START) state_nxt = RUN;
            end
            RUN:  if (last) state_nxt = FIN;
            FIN: begin
                DONE      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        csum    = {1'b0, opa[int'(idx)*CHUNK +: CHUNK]}
                + {1'b0, opb[int'(idx)*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, cin};
        acc_nxt = acc;
        acc_nxt[int'(idx)*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            cin      <= 1'b0;
            idx      <= '0;
            RESULT   <= '0;
            CARRY    <= 1'b0;
            OVERFLOW <= 1'b0;
            ZERO     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    opa <= A;
                    opb <= B ^ {WIDTH{SUB}};
                    cin <= SUB;
                    idx <= '0;
                    acc <= '0;
                end
                RUN: begin
                    acc <= acc_nxt;
                    cin <= csum[CHUNK];
                    idx <= idx + 1'b1;
                    // Outputs only move on the final chunk; partial sums stay internal.
                    if (last) begin
                        RESULT   <= acc_nxt;
                        CARRY    <= csum[CHUNK];
                        OVERFLOW <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                                    (acc_nxt[WIDTH-1] != opa[WIDTH-1]);
                        ZERO     <= (acc_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/adder_sub_serial.md
Name: adder_sub_serial

Overview:
- Parametrised, multi-cycle add/subtract unit. It is the successor to the combinational operand-invert stage.
- It inverts operand B and injects carry-in when SUB=1, then adds CHUNK bits per cycle, so wide datapaths close timing.
- Sits beside the ALU for wide or low-area arithmetic.
- Start/done handshake; produces registered result plus carry, overflow and zero flags.

Parameters:
- WIDTH, 32: operand/result width in bits.
- CHUNK, 8: bits added per cycle. WIDTH must be a multiple of CHUNK. N = WIDTH/CHUNK.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-low reset.
- START  input  1  request; accepted only when READY=1.
- SUB  input  1  0 = A+B, 1 = A-B (B inverted, carry-in 1); sampled with START.
- A  input  WIDTH  operand A; sampled with START.
- B  input  WIDTH  operand B; sampled with START.
- READY  output  1  unit idle, will accept START.
- DONE  output  1  one-cycle pulse: RESULT/flags just updated.
- RESULT  output  WIDTH  sum/difference.
- CARRY  output  1  carry out of MSB; for SUB, 1 = no borrow.
- OVERFLOW  output  1  signed two's-complement overflow.
- ZERO  output  1  RESULT == 0.

Behaviour:
- Reset (RST=0 at a rising edge):
  - state goes to IDLE; operand, carry and chunk-counter registers clear.
  - RESULT, CARRY, OVERFLOW, ZERO and DONE go to 0.
  - READY is 0 while RST=0 and 1 in the first cycle after release.
- Reset mid-operation aborts: no DONE is produced and outputs go to 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - READY=1.
  - START=1 latches opa=A, opb=B XOR {WIDTH{SUB}}, cin=SUB, idx=0, then goes to RUN.
  - START=0 stays in IDLE.
- RUN:
  - READY=0. Each cycle computes {c, s} = opa[idx chunk] + opb[idx chunk] + cin.
  - s is stored into the internal accumulator chunk idx; cin <= c; idx <= idx+1.
  - Chunk 0 is the LSB chunk.
  - When idx == N-1 the cycle writes the last chunk and then:
    - RESULT <= full accumulated value, including the last chunk.
    - CARRY <= final c.
    - OVERFLOW <= (opa[MSB] == opb[MSB]) && (result[MSB] != opa[MSB]), using the inverted opb.
    - ZERO <= (result == 0).
    - State goes to FIN.
- FIN: DONE=1 for exactly this cycle, READY=0. Next cycle goes to IDLE unconditionally.
- Latency: START high in cycle 0 gives RUN in cycles 1..N, DONE high in cycle N+1 and READY again in cycle N+2. Throughput is one operation per N+2 cycles.
- START while READY=0 (RUN or FIN) is ignored: no queueing, and in-flight operands are unaffected.
- A, B and SUB may change freely after acceptance.
- RESULT and flags hold their values from DONE until the next operation's DONE. They do not change during RUN; intermediate sums stay internal.
- Chunk carry wraps cleanly: the carry out of chunk k is the carry in of chunk k+1. The carry out of the MSB chunk is CARRY.
- Arithmetic is modulo 2^WIDTH.
- CHUNK == WIDTH is legal: N=1, DONE in cycle 2.
- The counter must be ceil(log2(N)) bits with a minimum of 1 bit.

Test Plan:
- WIDTH=32, CHUNK=8: START with SUB=0, A=0x000000FF, B=0x00000001 in cycle 0 -> DONE only in cycle 5; RESULT=0x00000100, CARRY=0, OVERFLOW=0, ZERO=0; READY=1 in cycle 6.
- SUB=1, A=5, B=5 -> RESULT=0, ZERO=1, CARRY=1, OVERFLOW=0. SUB=1, A=3, B=4 -> RESULT=0xFFFFFFFF, CARRY=0, ZERO=0.
- Add 0x7FFFFFFF+0x00000001 -> 0x80000000, OVERFLOW=1, CARRY=0. Sub 0x80000000-0x00000001 -> 0x7FFFFFFF, OVERFLOW=1, CARRY=1. Add 0xFFFFFFFF+0x00000001 -> 0, CARRY=1, ZERO=1, OVERFLOW=0.
- Accept 1+2, then pulse START with A=9, B=9 during cycles 2 and 5 -> ignored; one DONE in cycle 5 with RESULT=3; next accepted START only in cycle 6 or later.
- Accept an operation after a prior RESULT=0x1234, then drop RST in cycle 3 -> no DONE; RESULT/flags=0; READY=0 during reset, 1 the cycle after release; the next operation completes normally.
- Parameter sweep: WIDTH=16, CHUNK=4, SUB=1, 0x0003-0x0004 -> 0xFFFF, CARRY=0, DONE in cycle 5. WIDTH=16, CHUNK=16, 0x8000+0x8000 -> 0x0000, CARRY=1, OVERFLOW=1, ZERO=1, DONE in cycle 2.
